// File: rtl/execute_stage.sv
// MIPS EX stage: operand select, ALU control decode, ALU, branch target and
// destination register, registered into the EX/MEM boundary on the falling edge.
module execute_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] signExtend,
  input  logic [31:0] inData1,
  input  logic [31:0] inData2,
  input  logic [9:0]  inPC,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [1:0]  aluOp,
  input  logic        aluSrc,
  input  logic        inRegDst,
  output logic [9:0]  outPC,
  output logic        zero,
  output logic [31:0] aluResult,
  output logic [31:0] outData2,
  output logic [4:0]  wr
);

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_NONE
  } aluCtl_e;

  aluCtl_e     aluCtl;
  logic [31:0] operandB;
  logic [31:0] aluRes;
  logic [9:0]  branchTarget;
  logic [4:0]  writeReg;

  assign operandB     = aluSrc ? signExtend : inData2;
  assign branchTarget = inPC + signExtend[9:0];
  assign writeReg     = inRegDst ? rd : rt;

  // NOTE: the default before the case keeps every path assigned, so no latch.
  always_comb begin
    aluCtl = ALU_ADD;
    case (aluOp)
      2'b01: aluCtl = ALU_SUB;
      2'b10: begin
        case (signExtend[5:0])
          6'b100000: aluCtl = ALU_ADD;
          6'b100010: aluCtl = ALU_SUB;
          6'b100100: aluCtl = ALU_AND;
          6'b100101: aluCtl = ALU_OR;
          6'b100110: aluCtl = ALU_XOR;
          6'b100111: aluCtl = ALU_NOR;
          6'b101010: aluCtl = ALU_SLT;
          default:   aluCtl = ALU_NONE;
        endcase
      end
      default: aluCtl = ALU_ADD;
    endcase
  end

  always_comb begin
    aluRes = '0;
    case (aluCtl)
      ALU_ADD: aluRes = inData1 + operandB;
      ALU_SUB: aluRes = inData1 - operandB;
      ALU_AND: aluRes = inData1 & operandB;
      ALU_OR:  aluRes = inData1 | operandB;
      ALU_XOR: aluRes = inData1 ^ operandB;
      ALU_NOR: aluRes = ~(inData1 | operandB);
      ALU_SLT: aluRes = {31'd0, $signed(inData1) < $signed(operandB)};
      default: aluRes = '0;
    endcase
  end

  // Pipeline boundary captures on the falling edge; rising edges are ignored.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      outPC     <= '0;
      zero      <= 1'b0;
      aluResult <= '0;
      outData2  <= '0;
      wr        <= '0;
    end else begin
      outPC     <= branchTarget;
      zero      <= (aluRes == 32'd0);
      aluResult <= aluRes;
      outData2  <= inData2;
      wr        <= writeReg;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed test-plan vectors, reset and
// edge-sensitivity checks, then randomized traffic against a behavioural model.
module tb_execute_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] signExtend, inData1, inData2;
  logic [9:0]  inPC;
  logic [4:0]  rt, rd;
  logic [1:0]  aluOp;
  logic        aluSrc, inRegDst;
  logic [9:0]  outPC;
  logic        zero;
  logic [31:0] aluResult, outData2;
  logic [4:0]  wr;

  int nChecks = 0;
  int nFails  = 0;

  execute_stage dut (
    .clock(clock), .reset(reset), .signExtend(signExtend), .inData1(inData1),
    .inData2(inData2), .inPC(inPC), .rt(rt), .rd(rd), .aluOp(aluOp),
    .aluSrc(aluSrc), .inRegDst(inRegDst), .outPC(outPC), .zero(zero),
    .aluResult(aluResult), .outData2(outData2), .wr(wr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic setIn(input logic [1:0] op, input logic src, input logic dst,
                       input logic [31:0] se, input logic [31:0] a,
                       input logic [31:0] d2, input logic [9:0] pc);
    aluOp = op; aluSrc = src; inRegDst = dst;
    signExtend = se; inData1 = a; inData2 = d2; inPC = pc;
  endtask

  task automatic stepNeg();
    @(negedge clock);
    #1;
  endtask

  task automatic checkZero(input string tag);
    check({tag, ".aluResult"}, aluResult, 32'd0);
    check({tag, ".zero"}, {31'd0, zero}, 32'd0);
    check({tag, ".outPC"}, {22'd0, outPC}, 32'd0);
    check({tag, ".outData2"}, outData2, 32'd0);
    check({tag, ".wr"}, {27'd0, wr}, 32'd0);
  endtask

  // Reference model: the ALU rules evaluated with plain integer arithmetic.
  logic [31:0] mRes;
  logic        mZero;
  logic [9:0]  mPC;
  logic [31:0] mData2;
  logic [4:0]  mWr;

  task automatic model();
    longint a, b, r;
    int     sa, sb, pcSum;
    logic [31:0] bv;
    bv = aluSrc ? signExtend : inData2;
    a  = longint'(inData1);
    b  = longint'(bv);
    sa = int'(inData1);
    sb = int'(bv);
    r  = 0;
    if (aluOp == 2'd1) r = a - b;
    else if (aluOp != 2'd2) r = a + b;
    else begin
      case (int'(signExtend[5:0]))
        32: r = a + b;
        34: r = a - b;
        36: r = longint'(inData1 & bv);
        37: r = longint'(inData1 | bv);
        38: r = longint'(inData1 ^ bv);
        39: r = longint'(~(inData1 | bv));
        42: r = (sa < sb) ? 1 : 0;
        default: r = 0;
      endcase
    end
    mRes   = r[31:0];
    mZero  = (mRes == 32'd0);
    pcSum  = (int'(inPC) + int'(signExtend[9:0])) % 1024;
    mPC    = pcSum[9:0];
    mData2 = inData2;
    mWr    = inRegDst ? rd : rt;
  endtask

  task automatic checkModel(input string tag);
    check({tag, ".aluResult"}, aluResult, mRes);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, mZero});
    check({tag, ".outPC"}, {22'd0, outPC}, {22'd0, mPC});
    check({tag, ".outData2"}, outData2, mData2);
    check({tag, ".wr"}, {27'd0, wr}, {27'd0, mWr});
  endtask

  logic [5:0] functs [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a};

  initial begin
    reset = 1'b1; rt = 5'd1; rd = 5'd2;
    setIn(2'b10, 1'b0, 1'b0, 32'h20, 32'd8, 32'd3, 10'd512);
    #2;
    checkZero("reset_init");
    stepNeg();
    checkZero("reset_hold_edge");

    // Release between edges: nothing loads until the next falling edge.
    reset = 1'b0;
    #2;
    checkZero("release_wait");
    stepNeg();
    check("add.aluResult", aluResult, 32'd11);
    check("add.zero", {31'd0, zero}, 32'd0);
    check("add.wr", {27'd0, wr}, 32'd1);
    check("add.outData2", outData2, 32'd3);
    check("add.outPC", {22'd0, outPC}, 32'd544);

    setIn(2'b10, 1'b0, 1'b1, 32'h22, 32'd65271, 32'd65261, 10'd512);
    stepNeg();
    check("sub.aluResult", aluResult, 32'd10);
    check("sub.wr", {27'd0, wr}, 32'd2);

    setIn(2'b10, 1'b0, 1'b0, 32'h2a, 32'd456758797, 32'd456758798, 10'd0);
    stepNeg();
    check("slt_lt", aluResult, 32'd1);
    setIn(2'b10, 1'b0, 1'b0, 32'h2a, 32'd456758798, 32'd456758797, 10'd0);
    stepNeg();
    check("slt_ge", aluResult, 32'd0);
    setIn(2'b10, 1'b0, 1'b0, 32'h2a, 32'hFFFF_FFFF, 32'd0, 10'd0);
    stepNeg();
    check("slt_signed", aluResult, 32'd1);

    setIn(2'b10, 1'b0, 1'b0, 32'h24, 32'd65879007, 32'd12364546, 10'd0);
    stepNeg();
    check("and", aluResult, 32'h00AC2B02);
    setIn(2'b10, 1'b0, 1'b0, 32'h25, 32'd65879007, 32'd12364546, 10'd0);
    stepNeg();
    check("or", aluResult, 32'h03FDBBDF);
    setIn(2'b10, 1'b0, 1'b0, 32'h3f, 32'd5, 32'd7, 10'd0);
    stepNeg();
    check("bad_funct.aluResult", aluResult, 32'd0);
    check("bad_funct.zero", {31'd0, zero}, 32'd1);

    setIn(2'b00, 1'b1, 1'b1, 32'd16, 32'd10, 32'd30, 10'd512);
    stepNeg();
    check("lw.aluResult", aluResult, 32'd26);
    check("lw.outData2", outData2, 32'd30);
    check("lw.wr", {27'd0, wr}, 32'd2);
    check("lw.outPC", {22'd0, outPC}, 32'd528);

    setIn(2'b01, 1'b0, 1'b0, 32'd2, 32'd10, 32'd10, 10'd512);
    stepNeg();
    check("beq_eq.aluResult", aluResult, 32'd0);
    check("beq_eq.zero", {31'd0, zero}, 32'd1);
    check("beq_eq.outPC", {22'd0, outPC}, 32'd514);
    setIn(2'b01, 1'b0, 1'b0, 32'd2, 32'd10, 32'd11, 10'd512);
    stepNeg();
    check("beq_ne.zero", {31'd0, zero}, 32'd0);
    check("beq_ne.aluResult", aluResult, 32'hFFFF_FFFF);

    // Branch target wraps modulo 1024.
    setIn(2'b11, 1'b0, 1'b0, 32'h0000_03F0, 32'd1, 32'd2, 10'd1000);
    stepNeg();
    check("pc_wrap", {22'd0, outPC}, 32'd984);
    check("aluop11_add", aluResult, 32'd3);

    // Rising edge must not disturb the held outputs.
    model();
    setIn(2'b10, 1'b0, 1'b1, 32'h26, 32'h1234_5678, 32'h0F0F_0F0F, 10'd77);
    @(posedge clock);
    #1;
    checkModel("rise_hold");
    model();
    stepNeg();
    checkModel("xor_after_rise");

    // Asynchronous reset mid-cycle, held across a falling edge, then released.
    #2;
    reset = 1'b1;
    #1;
    checkZero("reset_async");
    stepNeg();
    checkZero("reset_held");
    reset = 1'b0;
    model();
    stepNeg();
    checkModel("reset_reload");

    for (int i = 0; i < 300; i++) begin
      logic [31:0] se;
      se = $urandom;
      if ($urandom_range(3) != 0) se[5:0] = functs[$urandom_range(6)];
      aluOp = 2'($urandom_range(3));
      aluSrc = 1'($urandom_range(1));
      inRegDst = 1'($urandom_range(1));
      signExtend = se;
      inData1 = $urandom;
      inData2 = ($urandom_range(4) == 0) ? inData1 : $urandom;
      inPC = 10'($urandom);
      rt = 5'($urandom);
      rd = 5'($urandom);
      model();
      stepNeg();
      checkModel($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
